// File: rtl/universal_register.sv
// WIDTH-bit universal register: clear/preset, parallel load, single-step shift/rotate,
// and a multi-cycle rotate-by-N engine with a busy/done handshake.
module universal_register #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              AW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic          dir;   // 0: rotate left, 1: rotate right

    function automatic logic [WIDTH-1:0] rol1(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], x[WIDTH-1]};
    endfunction

    function automatic logic [WIDTH-1:0] ror1(input logic [WIDTH-1:0] x);
        return {x[0], x[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk) begin
        // NOTE: done defaults low every edge with a non-blocking assignment, so any
        // later assignment in this block overrides it and the pulse lasts one cycle.
        done <= 1'b0;
        if (clr) begin
            q     <= RESET_VAL;
            state <= IDLE;
            cnt   <= '0;
            dir   <= 1'b0;
            busy  <= 1'b0;
        end else if (pre) begin
            q     <= '1;
            state <= IDLE;
            busy  <= 1'b0;
        end else if (state == RUN) begin
            q   <= dir ? ror1(q) : rol1(q);
            cnt <= cnt - 1'b1;
            if (cnt == AW'(1)) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end else if (en) begin
            unique case (mode)
                3'd0: q <= q;
                3'd1: q <= d;
                3'd2: q <= {q[WIDTH-2:0], sin_r};
                3'd3: q <= {sin_l, q[WIDTH-1:1]};
                3'd4: q <= rol1(q);
                3'd5: q <= ror1(q);
                default: begin
                    // A zero amount completes immediately without entering RUN.
                    if (amt == '0) begin
                        done <= 1'b1;
                    end else begin
                        cnt   <= amt;
                        dir   <= mode[0];
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
            endcase
        end
    end

    assign qn     = ~q;
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule
